sdr_wb_bist: RTL

SDR_WB_BIST -- requirements
Module: sdr_wb_bist

---
 rtl/sdr_wb_bist_pkg.sv | 27 ++
 rtl/sdr_bist_patgen.sv | 30 +++
 rtl/sdr_wb_bist.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sdr_wb_bist_pkg.sv
// Shared constants for the SDRAM Wishbone BIST: FSM encoding,
// LFSR seed/taps, pattern selects and the LFSR step function.
package sdr_wb_bist_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;
  // Galois right-shift mask for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [1:0] PAT_INDEX = 2'd0;
  localparam logic [1:0] PAT_INV   = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] v
  );
    lfsr_next = {1'b0, v[31:1]}
              ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/sdr_bist_patgen.sv
// Pattern generator: maps word index / LFSR state to test data.
// Ports: pat (select), idx (word index), lfsr (state), data (word).
module sdr_bist_patgen
  import sdr_wb_bist_pkg::*;
#(
  parameter int LW = 16
) (
  input  logic [1:0]    pat,
  input  logic [LW-1:0] idx,
  input  logic [31:0]   lfsr,
  output logic [31:0]   data
);

  logic [31:0] idx_ext;

  always_comb begin
    idx_ext = 32'(idx);
    data    = '0;
    unique case (1'b1)
      (pat == PAT_INDEX): data = idx_ext;
      (pat == PAT_INV):   data = ~idx_ext;
      (pat == PAT_LFSR):  data = lfsr;
      (pat == PAT_CHECK):
        data = idx_ext[0] ? 32'hAAAA_AAAA
                          : 32'h5555_5555;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/sdr_wb_bist.sv
// SDRAM BIST Wishbone master: writes a pattern over len words,
// reads it back, counts mismatches and ack timeouts.
// Ports: wb_* Wishbone master, bist_* control/status, sdr_init_done.
module sdr_wb_bist
  import sdr_wb_bist_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int LW     = 16,
  parameter int TO_W   = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              sdr_init_done,
  input  logic              bist_start,
  input  logic [APP_AW-1:0] bist_base_addr,
  input  logic [LW-1:0]     bist_len,
  input  logic [1:0]        bist_pat,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [LW-1:0]     bist_err_cnt,
  output logic [APP_AW-1:0] bist_fail_addr
);

  // abort on the stb cycle where the count would reach all-ones
  localparam logic [TO_W-1:0] TO_LAST =
    {{(TO_W-1){1'b1}}, 1'b0};

  logic [2:0]        state_q, state_d;
  logic [APP_AW-1:0] base_q, base_d;
  logic [LW-1:0]     len_q, len_d;
  logic [1:0]        pat_q, pat_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              stb_q, stb_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              to_q, to_d;
  logic [LW-1:0]     err_q, err_d;
  logic [APP_AW-1:0] fail_q, fail_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [APP_AW-1:0] addr;
  logic [31:0]       pat_data;
  logic              last;
  logic              err_ev;
  logic              fin;

  sdr_bist_patgen #(
    .LW (LW)
  ) u_patgen (
    .pat  (pat_q),
    .idx  (idx_q),
    .lfsr (lfsr_q),
    .data (pat_data)
  );

  assign addr = base_q + APP_AW'({idx_q, 2'b00});
  assign last = (idx_q == len_q - LW'(1));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    stb_d    = stb_q;
    to_cnt_d = to_cnt_q;
    to_d     = to_q;
    err_d    = err_q;
    fail_d   = fail_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_ev   = 1'b0;
    fin      = 1'b0;

    unique case (1'b1)
      (state_q == ST_IDLE),
      (state_q == ST_DONE): begin
        if (bist_start) begin
          base_d  = bist_base_addr & ~APP_AW'(3);
          len_d   = bist_len;
          pat_d   = bist_pat;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          state_d = ST_WAIT;
        end
      end
      (state_q == ST_WAIT): begin
        if (len_q == '0) begin
          state_d = ST_DONE;
          fin     = 1'b1;
        end else if (sdr_init_done) begin
          state_d = ST_WR;
          idx_d   = '0;
          lfsr_d  = LFSR_SEED;
          stb_d   = 1'b0;
        end
      end
      (state_q == ST_WR),
      (state_q == ST_RD): begin
        if (!stb_q) begin
          stb_d    = 1'b1;
          to_cnt_d = '0;
        end else if (wb_ack_i) begin
          stb_d  = 1'b0;
          idx_d  = idx_q + LW'(1);
          lfsr_d = lfsr_next(lfsr_q);
          if (state_q == ST_RD &&
              wb_dat_i != dw'(pat_data))
            err_ev = 1'b1;
          if (last) begin
            if (state_q == ST_WR) begin
              state_d = ST_RD;
              idx_d   = '0;
              lfsr_d  = LFSR_SEED;
            end else begin
              state_d = ST_DONE;
              fin     = 1'b1;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          stb_d   = 1'b0;
          err_ev  = 1'b1;
          to_d    = 1'b1;
          state_d = ST_DONE;
          fin     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase

    if (err_ev) begin
      if (err_q != '1)
        err_d = err_q + LW'(1);
      if (err_q == '0)
        fail_d = addr;
    end

    if (fin) begin
      done_d = 1'b1;
      pass_d = (err_d == '0) && !to_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      idx_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      stb_q    <= 1'b0;
      to_cnt_q <= '0;
      to_q     <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
      stb_q    <= stb_d;
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign wb_cyc_o  = stb_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = stb_q && (state_q == ST_WR);
  assign wb_addr_o = stb_q ? addr : '0;
  assign wb_dat_o  = wb_we_o ? dw'(pat_data) : '0;
  assign wb_sel_o  = stb_q ? '1 : '0;
  assign wb_cti_o  = 3'b000;

  assign bist_busy = (state_q == ST_WAIT) ||
                     (state_q == ST_WR) ||
                     (state_q == ST_RD);
  assign bist_done      = done_q;
  assign bist_pass      = pass_q;
  assign bist_err_cnt   = err_q;
  assign bist_fail_addr = fail_q;

endmodule
